// File: rtl/decoder2to4_buf.sv
/*----------------------------------------------------------------------------
 * decoder2to4_buf: 2-to-4 one-hot decoder behind a 2-entry valid/ready FIFO.
 * Optional per-line saturating hit counters when DECODER2TO4_HITCNT_EN is set.
 * Revision: 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

module decoder2to4_buf #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         a,
  input  logic               en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         y,
  output logic [1:0]         count,
  output logic [4*CNT_W-1:0] hit_cnt
);

  logic [1:0] count_q, count_d;
  logic [3:0] slot0_q, slot0_d;
  logic [3:0] slot1_q, slot1_d;
  logic       push;
  logic       pop;
  logic [3:0] new_entry;

  // in_ready depends only on stored occupancy and reset, never on out_ready
  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign y         = out_valid ? slot0_q : 4'b0000;
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign new_entry = en ? (4'b0001 << a) : 4'b0000;

  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (push && pop) begin
      // Only reachable with one entry held: the new entry becomes the head
      slot0_d = new_entry;
    end else if (pop) begin
      slot0_d = slot1_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) slot0_d = new_entry;
      else                 slot1_d = new_entry;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      slot0_q <= 4'b0000;
      slot1_q <= 4'b0000;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

`ifdef DECODER2TO4_HITCNT_EN
  logic [CNT_W-1:0] hit_q [4];
  logic [CNT_W-1:0] hit_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hit_d[i] = hit_q[i];
      if (push && en && (a == 2'(i)) && (hit_q[i] != {CNT_W{1'b1}}))
        hit_d[i] = hit_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) hit_q[i] <= '0;
      else     hit_q[i] <= hit_d[i];
    end
  end

  assign hit_cnt = {hit_q[3], hit_q[2], hit_q[1], hit_q[0]};
`else
  assign hit_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/decoder2to4_buf.md
DECODER2TO4_BUF -- requirements
Module: decoder2to4_buf

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-line hit counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  producer presents a code on a/en.
REQ-005 in_ready  output  1  block can accept a code this cycle.
REQ-006 a  input  2  binary code to decode.
REQ-007 en  input  1  decode enable; 0 = entry decodes to all-zero.
REQ-008 out_valid  output  1  y holds a decoded entry.
REQ-009 out_ready  input  1  consumer accepts the current y.
REQ-010 y  output  4  one-hot decoded value (y[i] = 1 for a = i).
REQ-011 count  output  2  buffer occupancy, 0..2.
REQ-012 hit_cnt  output  4*CNT_W  per-line hit counters, line i at bits [i*CNT_W +: CNT_W].

Function
REQ-013 Push = in_valid && in_ready; pop = out_valid && out_ready; both evaluated on the same rising edge.
REQ-014 Pushed entry value = en ? (4'b0001 << a) : 4'b0000, captured at the push edge.
REQ-015 Buffer: 2-entry FIFO, strict arrival order, no entry lost or duplicated.
REQ-016 in_ready = (count != 2) && !rst; no combinational path from out_ready to in_ready.
REQ-017 out_valid = (count != 0); y = head entry when out_valid = 1, else 4'b0000.
REQ-018 Latency: push at edge k into an empty buffer -> out_valid = 1 and y valid immediately after edge k.
REQ-019 y and out_valid hold stable while out_valid = 1 and out_ready = 0.
REQ-020 count = 0, push only -> 1; count = 1, push and pop -> stays 1, y advances to the new entry; count = 1, pop only -> 0.
REQ-021 count = 2 -> push impossible (in_ready = 0); pop -> 1 and the second entry becomes the head.
REQ-022 count = 0 with out_ready = 1 -> no pop, no state change.
REQ-023 An en = 0 entry occupies a slot and is delivered as y = 4'b0000 with out_valid = 1.

Reset
REQ-024 While rst = 1 at an edge: count = 0, out_valid = 0, y = 0, all hit counters = 0, buffer contents discarded.
REQ-025 Reset takes priority over a simultaneous push or pop; in-flight entries are dropped, not delivered.
REQ-026 in_ready = 0 while rst = 1; in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro DECODER2TO4_HITCNT_EN, when defined, enables hit counters: on each push with en = 1, hit_cnt line a increments by 1.
REQ-028 A hit counter saturates at 2^CNT_W-1 and does not wrap; en = 0 pushes leave all counters unchanged.
REQ-029 Without DECODER2TO4_HITCNT_EN: hit_cnt is tied to 0, no counter registers are built, and all other behaviour is identical.

Verification
REQ-030 Reset, then push a = 0,1,2,3 (en = 1) with out_ready = 1 -> y = 1,2,4,8 one cycle after each push; count stays <= 1.
REQ-031 out_ready = 0, push a = 1 then a = 3 -> count = 2, in_ready = 0, y = 4'b0010 held; raise out_ready -> y = 2 then 8, then out_valid = 0.
REQ-032 count = 1 (head a = 2), simultaneous push a = 0 and pop -> next cycle count = 1, y = 4'b0001.
REQ-033 Push a = 2 with en = 0 -> out_valid = 1, y = 4'b0000; with the macro defined, hit_cnt is unchanged.
REQ-034 Macro defined, CNT_W = 2, push a = 1 five times -> line-1 hit counter = 3 (saturated), other lines 0.
REQ-035 Buffer full (count = 2), assert rst for 1 cycle -> count = 0, out_valid = 0, y = 0, hit counters 0; in_ready = 1 the next cycle.
